// File: rtl/multi_divi_index_gen.sv
// multi_divi_index_gen
// Walks positions j of a stored GF(A) symbol row and, for every alternative
// symbol a != x[j], emits one beat of multiply/divide table indices for the
// position and its partner p = (j+I) mod J.

module multi_divi_index_gen #(
    parameter int J = 14,
    parameter int I = 7,
    parameter int A = 4,
    localparam int AWIDTH  = $clog2(A) + 1,
    localparam int J_WIDTH = $clog2(J) + 1,
    localparam int SW      = $clog2(A),
    localparam int IW      = 2 * SW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [J*AWIDTH-1:0]   x_initial,
    input  logic                  x_initial_tvalid,
    input  logic                  start_gen,
    input  logic [J_WIDTH-1:0]    J_index,
    output logic [IW-1:0]         mutli_col_idx1,
    output logic [IW-1:0]         mutli_col_idx2,
    output logic [J_WIDTH-1:0]    multi_row_idx,
    output logic [J_WIDTH-1:0]    multi_row_idx2,
    output logic [IW-1:0]         divi_col_idx1,
    output logic [IW-1:0]         divi_col_idx2,
    output logic [J_WIDTH-1:0]    divi_row_idx,
    output logic [J_WIDTH-1:0]    divi_row_idx2,
    output logic                  index_out_tvalid
);

    localparam int JIW = (J > 1) ? $clog2(J) : 1;
    localparam logic [SW:0] A_END = (SW+1)'(A);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]         state;
    logic [SW-1:0]      x_mem  [J];
    logic [SW-1:0]      x_view [J];
    logic               load_en;

    logic [J_WIDTH-1:0] j_cur;
    logic [SW-1:0]      a_cur;
    logic [J_WIDTH-1:0] n_lat;

    logic [J_WIDTH-1:0] n_clamp;
    logic [J_WIDTH-1:0] j_inc;
    logic [J_WIDTH-1:0] j_nxt;
    logic [J_WIDTH-1:0] p_nxt;
    logic [SW:0]        a_try;
    logic [SW:0]        a_nxt;
    logic               nxt_valid;
    logic [SW-1:0]      xj_nxt;
    logic [SW-1:0]      xp_nxt;

    // Upper bits of each symbol field are don't-care; collected here so they are visibly sunk.
    logic               fields_unused;

    // Smallest candidate >= start that differs from skip; A_END means none left.
    function automatic logic [SW:0] next_cand(input logic [SW:0] start, input logic [SW-1:0] skip);
        if (start == {1'b0, skip}) return start + 1'b1;
        return start;
    endfunction

    // Partner position (j+I) mod J without a divider, valid for j < J and I < J.
    function automatic logic [J_WIDTH-1:0] partner(input logic [J_WIDTH-1:0] j);
        logic [J_WIDTH:0] sum;
        sum = {1'b0, j} + (J_WIDTH+1)'(I);
        if (sum < (J_WIDTH+1)'(J)) return sum[J_WIDTH-1:0];
        return J_WIDTH'(sum - (J_WIDTH+1)'(J));
    endfunction

    assign load_en = (state == S_IDLE) && x_initial_tvalid;

    // Row as seen this cycle: a load in IDLE is forwarded so a same-cycle start uses the new row.
    always_comb begin
        for (int unsigned k = 0; k < J; k++) begin
            x_view[k] = load_en ? x_initial[(J-1-k)*AWIDTH +: SW] : x_mem[k];
        end
        fields_unused = ^x_initial ^ a_nxt[SW];
    end

    // Next (j, a) candidate and whether another beat follows.
    always_comb begin
        n_clamp   = (J_index > J_WIDTH'(J)) ? J_WIDTH'(J) : J_index;
        j_inc     = j_cur + 1'b1;
        a_try     = '0;
        nxt_valid = 1'b0;
        j_nxt     = '0;
        a_nxt     = '0;
        if (state == S_IDLE) begin
            if (start_gen && (n_clamp != '0)) begin
                nxt_valid = 1'b1;
                a_nxt     = next_cand('0, x_view[0]);
            end
        end else begin
            a_try = next_cand({1'b0, a_cur} + 1'b1, x_view[j_cur[JIW-1:0]]);
            if (a_try < A_END) begin
                nxt_valid = 1'b1;
                j_nxt     = j_cur;
                a_nxt     = a_try;
            end else if (j_inc < n_lat) begin
                nxt_valid = 1'b1;
                j_nxt     = j_inc;
                a_nxt     = next_cand('0, x_view[j_inc[JIW-1:0]]);
            end
        end
        p_nxt  = partner(j_nxt);
        xj_nxt = x_view[j_nxt[JIW-1:0]];
        xp_nxt = x_view[p_nxt[JIW-1:0]];
    end

    // Symbol row storage; loads accepted only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < J; k++) begin
                x_mem[k] <= '0;
            end
        end else if (load_en) begin
            for (int unsigned k = 0; k < J; k++) begin
                x_mem[k] <= x_view[k];
            end
        end
    end

    // FSM, walk counters and registered index beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            j_cur            <= '0;
            a_cur            <= '0;
            n_lat            <= '0;
            index_out_tvalid <= 1'b0;
            mutli_col_idx1   <= '0;
            mutli_col_idx2   <= '0;
            multi_row_idx    <= '0;
            multi_row_idx2   <= '0;
            divi_col_idx1    <= '0;
            divi_col_idx2    <= '0;
            divi_row_idx     <= '0;
            divi_row_idx2    <= '0;
        end else begin
            index_out_tvalid <= nxt_valid;
            if (state == S_IDLE && start_gen) begin
                n_lat <= n_clamp;
            end
            if (nxt_valid) begin
                state          <= S_RUN;
                j_cur          <= j_nxt;
                a_cur          <= a_nxt[SW-1:0];
                mutli_col_idx1 <= {xj_nxt, a_nxt[SW-1:0]};
                mutli_col_idx2 <= {xp_nxt, a_nxt[SW-1:0]};
                divi_col_idx1  <= {a_nxt[SW-1:0], xj_nxt};
                divi_col_idx2  <= {a_nxt[SW-1:0], xp_nxt};
                multi_row_idx  <= j_nxt;
                multi_row_idx2 <= p_nxt;
                divi_row_idx   <= j_nxt;
                divi_row_idx2  <= p_nxt;
            end else begin
                state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_multi_divi_index_gen.sv
// Self-checking bench for multi_divi_index_gen: directed table of runs,
// fixed-beat spot checks, random rows against a list-building reference model,
// and control corner cases (mid-run start/load, reset abort).

module tb_multi_divi_index_gen;

    localparam int J  = 14;
    localparam int I  = 7;
    localparam int A  = 4;
    localparam int AW = 3;
    localparam int JW = 5;
    localparam int IW = 4;
    localparam int RW = J * AW;

    typedef struct packed {
        logic [IW-1:0] m1;
        logic [IW-1:0] m2;
        logic [IW-1:0] d1;
        logic [IW-1:0] d2;
        logic [JW-1:0] r1;
        logic [JW-1:0] r2;
        logic [JW-1:0] dr1;
        logic [JW-1:0] dr2;
    } beat_t;

    typedef struct {
        int beat;
        int m1; int m2; int d1; int d2; int r1; int r2;
    } beat_vec_t;

    typedef struct {
        int pattern;   // 0 = all-zero row, 1 = alternating row
        bit do_load;
        int jidx;
        bit mid_start;
        bit mid_load;
        int exp_beats;
    } run_vec_t;

    logic              clk;
    logic              rst_n;
    logic [RW-1:0]     x_initial;
    logic              x_initial_tvalid;
    logic              start_gen;
    logic [JW-1:0]     J_index;
    logic [IW-1:0]     mutli_col_idx1, mutli_col_idx2, divi_col_idx1, divi_col_idx2;
    logic [JW-1:0]     multi_row_idx, multi_row_idx2, divi_row_idx, divi_row_idx2;
    logic              index_out_tvalid;
    beat_t             dut_beat;

    int checks = 0;
    int errors = 0;

    logic [RW-1:0] stored;
    logic [RW-1:0] alt_row;
    logic [RW-1:0] zero_row;
    logic [RW-1:0] rnd_row;
    beat_t exp_q[$];
    beat_t cap[$];

    multi_divi_index_gen #(.J(J), .I(I), .A(A)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .x_initial        (x_initial),
        .x_initial_tvalid (x_initial_tvalid),
        .start_gen        (start_gen),
        .J_index          (J_index),
        .mutli_col_idx1   (mutli_col_idx1),
        .mutli_col_idx2   (mutli_col_idx2),
        .multi_row_idx    (multi_row_idx),
        .multi_row_idx2   (multi_row_idx2),
        .divi_col_idx1    (divi_col_idx1),
        .divi_col_idx2    (divi_col_idx2),
        .divi_row_idx     (divi_row_idx),
        .divi_row_idx2    (divi_row_idx2),
        .index_out_tvalid (index_out_tvalid)
    );

    assign dut_beat = {mutli_col_idx1, mutli_col_idx2, divi_col_idx1, divi_col_idx2,
                       multi_row_idx, multi_row_idx2, divi_row_idx, divi_row_idx2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sym(input logic [RW-1:0] row, input int j);
        logic [AW-1:0] f;
        f = row[(J-1-j)*AW +: AW];
        return int'(f) % A;
    endfunction

    // Reference: list every (j, a != x[j]) pair in order and compute indices arithmetically.
    task automatic build_model(input logic [RW-1:0] row, input int jidx);
        int n;
        int xj, xp, p;
        beat_t b;
        n = (jidx > J) ? J : jidx;
        exp_q.delete();
        for (int j = 0; j < n; j++) begin
            p  = (j + I) % J;
            xj = sym(row, j);
            xp = sym(row, p);
            for (int a = 0; a < A; a++) begin
                if (a != xj) begin
                    b.m1  = IW'(xj * A + a);
                    b.m2  = IW'(xp * A + a);
                    b.d1  = IW'(a * A + xj);
                    b.d2  = IW'(a * A + xp);
                    b.r1  = JW'(j);
                    b.r2  = JW'(p);
                    b.dr1 = JW'(j);
                    b.dr2 = JW'(p);
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    // One generation run with an optional load, bounded capture window, then comparison.
    task automatic do_run(input logic [RW-1:0] row, input bit do_load, input int jidx,
                          input bit mid_start, input bit mid_load);
        int win;
        int first;
        int last;
        if (do_load) stored = row;
        build_model(stored, jidx);
        cap.delete();
        first = -1;
        last  = -1;
        win   = exp_q.size() + 6;
        @(negedge clk);
        x_initial        = row;
        x_initial_tvalid = do_load;
        J_index          = JW'(jidx);
        start_gen        = 1'b1;
        for (int c = 0; c < win; c++) begin
            @(negedge clk);
            start_gen        = mid_start && (c == 5);
            x_initial_tvalid = mid_load && (c == 2);
            x_initial        = (mid_load && (c == 2)) ? ~row : row;
            if (index_out_tvalid) begin
                cap.push_back(dut_beat);
                if (first < 0) first = c;
                last = c;
            end
        end
        start_gen        = 1'b0;
        x_initial_tvalid = 1'b0;
        check("beat_count", cap.size(), exp_q.size());
        if (exp_q.size() > 0) begin
            check("first_beat_cycle", first, 0);
            check("beats_contiguous", last - first + 1, exp_q.size());
        end
        for (int k = 0; k < cap.size() && k < exp_q.size(); k++) begin
            check("beat_fields", cap[k], exp_q[k]);
        end
    endtask

    beat_vec_t alt_vec[3];
    run_vec_t  runs[7];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        beat_t bv;

        alt_vec[0] = '{beat: 0,  m1: 1,  m2: 1, d1: 4,  d2: 4,  r1: 0, r2: 7};
        alt_vec[1] = '{beat: 3,  m1: 12, m2: 0, d1: 3,  d2: 0,  r1: 1, r2: 8};
        alt_vec[2] = '{beat: 20, m1: 3,  m2: 3, d1: 12, d2: 12, r1: 6, r2: 13};

        runs[0] = '{pattern: 1, do_load: 1, jidx: 7,  mid_start: 0, mid_load: 0, exp_beats: 21};
        runs[1] = '{pattern: 0, do_load: 1, jidx: 7,  mid_start: 0, mid_load: 0, exp_beats: 21};
        runs[2] = '{pattern: 0, do_load: 1, jidx: 0,  mid_start: 0, mid_load: 0, exp_beats: 0};
        runs[3] = '{pattern: 0, do_load: 1, jidx: 15, mid_start: 0, mid_load: 0, exp_beats: 42};
        runs[4] = '{pattern: 1, do_load: 1, jidx: 14, mid_start: 1, mid_load: 0, exp_beats: 42};
        runs[5] = '{pattern: 1, do_load: 0, jidx: 14, mid_start: 0, mid_load: 1, exp_beats: 42};
        runs[6] = '{pattern: 0, do_load: 1, jidx: 1,  mid_start: 0, mid_load: 0, exp_beats: 3};

        zero_row = '0;
        alt_row  = '0;
        for (int j = 0; j < 7; j++) begin
            alt_row[(J-1-j)*AW +: AW] = (j % 2 == 1) ? 3'b111 : 3'b000;
        end

        rst_n            = 1'b0;
        x_initial        = '0;
        x_initial_tvalid = 1'b0;
        start_gen        = 1'b0;
        J_index          = '0;
        stored           = '0;

        repeat (3) @(negedge clk);
        check("reset_valid", index_out_tvalid, 0);
        check("reset_fields", dut_beat, 0);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("idle_valid", index_out_tvalid, 0);
            check("idle_fields", dut_beat, 0);
        end

        // Alternating row with fixed-beat spot checks.
        do_run(alt_row, 1'b1, 7, 1'b0, 1'b0);
        foreach (alt_vec[v]) begin
            bv.m1  = IW'(alt_vec[v].m1);
            bv.m2  = IW'(alt_vec[v].m2);
            bv.d1  = IW'(alt_vec[v].d1);
            bv.d2  = IW'(alt_vec[v].d2);
            bv.r1  = JW'(alt_vec[v].r1);
            bv.r2  = JW'(alt_vec[v].r2);
            bv.dr1 = JW'(alt_vec[v].r1);
            bv.dr2 = JW'(alt_vec[v].r2);
            if (alt_vec[v].beat < cap.size())
                check("alt_spot_beat", cap[alt_vec[v].beat], bv);
            else
                check("alt_spot_present", cap.size(), alt_vec[v].beat + 1);
        end

        // Directed run table.
        foreach (runs[r]) begin
            do_run(runs[r].pattern == 1 ? alt_row : zero_row, runs[r].do_load, runs[r].jidx,
                   runs[r].mid_start, runs[r].mid_load);
            check("table_beat_count", cap.size(), runs[r].exp_beats);
        end

        // Random rows (full 3-bit fields exercise symbol reduction) and lengths.
        for (int t = 0; t < 8; t++) begin
            for (int j = 0; j < J; j++) begin
                rnd_row[(J-1-j)*AW +: AW] = AW'($urandom_range(0, 7));
            end
            do_run(rnd_row, 1'b1, int'($urandom_range(0, 20)), 1'b0, 1'b0);
        end

        // Reset mid-run aborts at once; stored row clears so an unloaded run uses zeros.
        @(negedge clk);
        x_initial        = alt_row;
        x_initial_tvalid = 1'b1;
        J_index          = JW'(14);
        start_gen        = 1'b1;
        @(negedge clk);
        x_initial_tvalid = 1'b0;
        start_gen        = 1'b0;
        repeat (3) @(negedge clk);
        check("midrun_valid_before_reset", index_out_tvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("reset_abort_valid", index_out_tvalid, 0);
        check("reset_abort_fields", dut_beat, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        stored = '0;
        do_run(alt_row, 1'b0, 14, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_divi_index_gen.md
Name: multi_divi_index_gen

Overview:
- Generates lookup-table addresses for GF(A) multiply/divide tables in the candidate-row search datapath.
- A reference symbol row x (J symbols) is loaded once.
- On start_gen, the block walks positions j = 0..J_index-1.
- For each j, it steps through every alternative symbol value a != x[j] and emits one set of multiply/divide row and column indices per cycle, for the downstream table banks.

Parameters:
- J, 14, symbols per row (positions)
- I, 7, partner offset; partner position p = (j+I) mod J; requires 1 <= I < J
- A, 4, alphabet size; must be a power of two >= 2
- Derived: AWIDTH = clog2(A)+1, J_WIDTH = clog2(J)+1, SW = clog2(A), IW = 2*SW (flat A*A table index width)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- x_initial  in  J*AWIDTH  symbol row; position j at bits [(J-1-j)*AWIDTH +: AWIDTH] (position 0 in MSBs)
- x_initial_tvalid  in  1  load strobe for x_initial
- start_gen  in  1  start-generation pulse
- J_index  in  J_WIDTH  number of positions to walk
- mutli_col_idx1  out  IW  multiply index x[j]*A + a
- mutli_col_idx2  out  IW  multiply index x[p]*A + a
- multi_row_idx  out  J_WIDTH  position j
- multi_row_idx2  out  J_WIDTH  partner position p
- divi_col_idx1  out  IW  divide index a*A + x[j]
- divi_col_idx2  out  IW  divide index a*A + x[p]
- divi_row_idx  out  J_WIDTH  position j (separate register copy)
- divi_row_idx2  out  J_WIDTH  partner position p
- index_out_tvalid  out  1  output beat valid

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset:
  - All outputs are 0, index_out_tvalid = 0.
  - Stored row = all 0; FSM = IDLE; counters = 0.
  - Asserting rst_n mid-run aborts immediately.
- Symbol reduction: only the low SW bits of each AWIDTH field are used. Stored value = field & (A-1); e.g. 3'b111 with A=4 becomes 3.
- Load:
  - In IDLE, x_initial_tvalid = 1 registers x_initial on that edge.
  - In RUN, x_initial_tvalid is ignored and the stored row is held.
  - Simultaneous load and start in IDLE: the load takes effect first, so the run uses the new row.
- FSM states: IDLE, RUN.
- IDLE -> RUN when start_gen = 1 is sampled:
  - Latch n = min(J_index, J).
  - If n = 0, stay in IDLE and emit nothing.
  - Set j = 0 and a = the first value in 0..A-1 that is not x[0].
- RUN operation:
  - Every cycle emits one registered beat: index_out_tvalid = 1 plus all eight indices for the current (j, a).
  - The first beat is visible the cycle after start_gen is sampled.
- Candidate order:
  - For each j, a ascends 0..A-1, skipping a == x[j].
  - After the last a, j increments.
  - Each position yields exactly A-1 beats.
  - Total beats = n*(A-1), back-to-back, with no gaps and no backpressure.
- After the last beat (j = n-1, last a), return to IDLE; index_out_tvalid drops the next cycle.
- start_gen during RUN is ignored.
- When index_out_tvalid = 0, index outputs hold their last values.
- Index arithmetic:
  - Unsigned; products fit in IW bits.
  - p = j+I if j+I < J, else j+I-J.

Test Plan:
- Reset then idle, no stimulus -> all outputs 0, index_out_tvalid stays 0.
- Alternating row (J=14, I=7, A=4): load positions 0..6 = 0,7,0,7,0,7,0 and positions 7..13 = 0; start_gen with J_index=7.
  - 21 consecutive valid beats.
  - Beat 0: j=0, a=1 -> mult1=1, mult2=1, div1=4, div2=4, rows 0/7.
  - Beat 3: j=1, a=0 -> mult1=12, mult2=0, div1=3, div2=0, rows 1/8.
  - Last beat: j=6, a=3 -> mult1=3, div1=12, rows 6/13.
- All-zero row, J_index=7 -> 21 beats; every position yields a = 1, 2, 3; mult1 = a, div1 = 4a; rows j / j+7.
- Boundaries:
  - J_index=0 -> no beats.
  - J_index=15 (> J) -> clamped to 14, giving 42 beats.
  - Positions 7..13 have partner p = j-7.
- Control corner cases:
  - start_gen pulsed again mid-run -> beat count unchanged.
  - x_initial_tvalid mid-run -> current run uses the old row.
- Reset mid-run -> index_out_tvalid = 0 and outputs = 0 immediately; a new start after reset produces a full sequence.
